riscv_core_dmem_responder: RTL and testbench
============================================

Name: riscv_core_dmem_responder

Overview:
- Memory-side responder for the data cache's line-refill and write-through request interface; it is the other end of the cache controller's read/write handshake.
- Serves 256-bit line reads and 64-bit strobed write-through stores from an internal line-organised backing memory, with a programmable fixed latency per request type.
- Used as the on-chip data memory in SoC builds and as the memory model in cache regression benches.

Parameters:
- ADDR_WIDTH, 64, byte address width
- CORE_DATA_WIDTH, 64, write data width
- AXI_DATA_WIDTH, 256, line width returned on reads (32 bytes)
- MEM_DEPTH, 1024, number of 256-bit lines (power of two)
- READ_LATENCY, 4, cycles from request acceptance to read done (>=1)
- WRITE_LATENCY, 2, cycles from request acceptance to write done (>=1)

Ports:
- i_clk, input, 1, clock
- i_rst_n, input, 1, reset, synchronous, active-low
- i_mem_read_req, input, 1, line read request, held high until done
- i_mem_read_address, input, ADDR_WIDTH, line-aligned byte address; bits [4:0] are ignored
- o_mem_read_done, output, 1, one-cycle pulse; o_mem_read_data is valid in this cycle
- o_mem_read_data, output, AXI_DATA_WIDTH, line data; byte 0 is bits [7:0]
- i_mem_write_valid, input, 1, store request, held high until done
- i_mem_write_address, input, ADDR_WIDTH, byte address of the store
- i_mem_write_data, input, CORE_DATA_WIDTH, store data, right-aligned (byte 0 = LSB)
- i_mem_write_strobe, input, 8, right-aligned byte enables (0x01, 0x03, 0x0F or 0xFF)
- o_mem_write_done, output, 1, one-cycle pulse; the store is committed
- o_mem_err, output, 1, pulses together with a done when the address is out of range
- o_busy, output, 1, high while a request is in flight (any state other than IDLE)

Behaviour:
- All registers, including the FSM state and latency counter, update on the i_clk rising edge.
- Reset (i_rst_n low at an edge):
  - state goes to IDLE and the counter clears.
  - o_mem_read_done, o_mem_write_done, o_mem_err, o_busy and o_mem_read_data reset to 0.
  - Memory contents are not cleared.
  - A reset mid-operation aborts the request: no done is produced and a pending write is not committed.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - If i_mem_write_valid, accept the write: capture address, data and strobe; load counter = WRITE_LATENCY-1; go to WR_WAIT.
  - Else if i_mem_read_req, accept the read: capture the line address; load counter = READ_LATENCY-1; go to RD_WAIT.
  - A write wins a simultaneous request; the read stays pending and is accepted later.
- RD_WAIT / WR_WAIT: decrement the counter each cycle. When the counter is 0, perform the access and go to DONE.
- DONE:
  - Exactly one cycle; the matching done pulse is high; next state is IDLE.
  - Requests are never accepted in DONE, so the requester has one cycle to drop req/valid.
- Latency: a request accepted in IDLE at cycle T produces done high during cycle T+LATENCY+1. This is READ_LATENCY+1 cycles for reads and WRITE_LATENCY+1 for writes.
- Requests are captured at acceptance. Input changes, or req/valid dropping, while busy have no effect; the transaction completes and done still pulses.
- Line index = address[4+log2(MEM_DEPTH):5].
- Out of range = any address bit above the index field is non-zero. For an out-of-range request:
  - a read returns all-zero data;
  - a write is discarded;
  - o_mem_err pulses with the done.
- Write merge:
  - Target doubleword = address[4:3].
  - Byte lanes = (strobe << address[2:0]) truncated to 8 bits; data is shifted left by 8*address[2:0].
  - Lanes shifted beyond byte 7 are dropped and no neighbouring doubleword is touched.
  - Unselected bytes of the line are unchanged.
- o_mem_read_data updates only in the read DONE cycle and holds its value otherwise.
- The write commit and the data read are both performed in the same cycle the FSM enters DONE, so a read following a write to the same line returns the merged data.

Test Plan:
- Reset, then write line 5 via backdoor = 0x1F..00 (byte i = i); read_req addr 0xA0 at T -> read_done only at T+5 with data byte i = i, o_busy high T+1..T+5, o_mem_err 0.
- Write addr 0xA3, data 0xBEEF, strobe 0x03 accepted at T -> write_done at T+3. A following read of 0xA0 returns bytes 3,4 = 0xEF,0xBE, all other bytes unchanged.
- read_req and write_valid both high in IDLE, write to 0xA8 data 0xFF strobe 0x01 -> write_done first, then the read is accepted in the first IDLE cycle after and returns byte 8 = 0xFF.
- Read addr 0x8000 (index out of range, MEM_DEPTH=1024) -> read_done with data 0 and o_mem_err=1 in the same cycle. Write to 0x8000 -> o_mem_err=1 and memory unchanged.
- Drop write_valid one cycle after acceptance -> write_done still pulses at T+3 and data is committed. Hold req high through DONE -> no re-accept until IDLE.
- Assert i_rst_n=0 during RD_WAIT -> no read_done; outputs 0 next cycle; memory contents preserved on a subsequent read.

Source files
------------

// File: rtl/riscv_core_dmem_responder.sv
// -----------------------------------------------------------------------------
// riscv_core_dmem_responder
//
// Memory-side responder for the data cache refill / write-through interface.
// Holds a line-organised backing store (MEM_DEPTH lines of AXI_DATA_WIDTH bits)
// and answers one request at a time after a fixed, per-type latency.
//
// Handshake: a requester raises i_mem_read_req or i_mem_write_valid and holds it
// until the matching one-cycle done pulse. Requests are only accepted in IDLE;
// everything needed is captured at acceptance, so later input changes (including
// dropping the request) do not affect the transaction. DONE lasts exactly one
// cycle and never accepts, giving the requester that cycle to drop its request.
// A write wins over a simultaneous read; the read stays pending.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_mem_read_req           line read request (held until done)
//   i_mem_read_address       byte address, bits [4:0] ignored
//   o_mem_read_done          one-cycle pulse, o_mem_read_data valid
//   o_mem_read_data          line data, byte 0 in bits [7:0]
//   i_mem_write_valid        store request (held until done)
//   i_mem_write_address      byte address of the store
//   i_mem_write_data         right-aligned store data
//   i_mem_write_strobe       right-aligned byte enables
//   o_mem_write_done         one-cycle pulse, store committed
//   o_mem_err                pulses with a done for an out-of-range address
//   o_busy                   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module riscv_core_dmem_responder #(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int MEM_DEPTH       = 1024,
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]      i_mem_read_address,
    output logic                       o_mem_read_done,
    output logic [AXI_DATA_WIDTH-1:0]  o_mem_read_data,
    input  logic                       i_mem_write_valid,
    input  logic [ADDR_WIDTH-1:0]      i_mem_write_address,
    input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
    input  logic [7:0]                 i_mem_write_strobe,
    output logic                       o_mem_write_done,
    output logic                       o_mem_err,
    output logic                       o_busy
);

    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // Counter only ever holds LATENCY-1 down to 0.
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_next;
    logic                        w_accept_wr;
    logic                        w_accept_rd;

    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [CORE_DATA_WIDTH-1:0]  r_wdata;
    logic [7:0]                  r_wstrb;
    logic                        r_is_wr;
    logic                        r_err;
    logic [AXI_DATA_WIDTH-1:0]   r_rdata;

    logic [AXI_DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic [IDX_W-1:0]            w_idx;
    logic                        w_oor;
    logic [1:0]                  w_dw;
    logic [2:0]                  w_off;
    logic [7:0]                  w_lanes;
    logic [CORE_DATA_WIDTH-1:0]  w_wshift;
    logic [AXI_DATA_WIDTH-1:0]   w_merged;
    logic                        w_access;

    // Address decode of the captured request.
    assign w_idx    = r_addr[5 +: IDX_W];
    assign w_oor    = |r_addr[ADDR_WIDTH-1:5+IDX_W];
    assign w_dw     = r_addr[4:3];
    assign w_off    = r_addr[2:0];
    // 8-bit result width truncates lanes shifted past byte 7, so a misaligned
    // store never spills into the neighbouring doubleword.
    assign w_lanes  = r_wstrb << w_off;
    assign w_wshift = r_wdata << {w_off, 3'b000};

    // The access happens on the edge that moves a WAIT state into DONE.
    assign w_access = ((r_state == RD_WAIT) || (r_state == WR_WAIT)) && (r_cnt == '0);

    assign o_mem_read_data = r_rdata;

    always_comb begin
        w_merged = r_mem[w_idx];
        for (int b = 0; b < 8; b++) begin
            if (w_lanes[b]) begin
                w_merged[int'(w_dw) * CORE_DATA_WIDTH + b * 8 +: 8] = w_wshift[b * 8 +: 8];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // FSM next state and outputs.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_accept_wr      = 1'b0;
        w_accept_rd      = 1'b0;
        o_mem_read_done  = 1'b0;
        o_mem_write_done = 1'b0;
        o_mem_err        = 1'b0;
        o_busy           = 1'b1;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_mem_write_valid) begin
                    w_accept_wr  = 1'b1;
                    w_cnt_next   = CNT_W'(WRITE_LATENCY - 1);
                    w_state_next = WR_WAIT;
                end else if (i_mem_read_req) begin
                    w_accept_rd  = 1'b1;
                    w_cnt_next   = CNT_W'(READ_LATENCY - 1);
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                o_mem_read_done  = ~r_is_wr;
                o_mem_write_done = r_is_wr;
                o_mem_err        = r_err;
                w_state_next     = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request capture and read data / error registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept_wr) begin
                r_addr  <= i_mem_write_address;
                r_wdata <= i_mem_write_data;
                r_wstrb <= i_mem_write_strobe;
                r_is_wr <= 1'b1;
            end else if (w_accept_rd) begin
                r_addr  <= i_mem_read_address;
                r_is_wr <= 1'b0;
            end
            if (w_access) begin
                r_err <= w_oor;
            end
            if (w_access && (r_state == RD_WAIT)) begin
                r_rdata <= w_oor ? '0 : r_mem[w_idx];
            end
        end
    end

    // Backing store: not reset. Gating with i_rst_n drops a write whose commit
    // edge coincides with reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_access && (r_state == WR_WAIT) && !w_oor) begin
            r_mem[w_idx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_riscv_core_dmem_responder.sv
// -----------------------------------------------------------------------------
// Directed bench for riscv_core_dmem_responder (default parameters).
// exp_line holds the hand-maintained expected contents of line 5 (0xA0..0xBF).
// -----------------------------------------------------------------------------
module tb_riscv_core_dmem_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_req;
    logic [63:0]  rd_addr;
    logic         rd_done;
    logic [255:0] rd_data;
    logic         wr_valid;
    logic [63:0]  wr_addr;
    logic [63:0]  wr_data;
    logic [7:0]   wr_strb;
    logic         wr_done;
    logic         mem_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_line;

    always #5 clk = ~clk;

    riscv_core_dmem_responder dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mem_read_req      (rd_req),
        .i_mem_read_address  (rd_addr),
        .o_mem_read_done     (rd_done),
        .o_mem_read_data     (rd_data),
        .i_mem_write_valid   (wr_valid),
        .i_mem_write_address (wr_addr),
        .i_mem_write_data    (wr_data),
        .i_mem_write_strobe  (wr_strb),
        .o_mem_write_done    (wr_done),
        .o_mem_err           (mem_err),
        .o_busy              (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: issue a store, return cycles to done (40 = timeout) and o_mem_err.
    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            input bit drop_early, output int lat, output logic err);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
        lat = 0;
        err = 1'b0;
        while (lat < 40) begin
            tick();
            lat++;
            if (wr_done) begin
                err = mem_err;
                break;
            end
            if (drop_early && lat == 1) begin
                wr_valid = 1'b0;
                wr_addr  = 64'h0;
                wr_data  = '1;
                wr_strb  = 8'hFF;
            end
        end
        wr_valid = 1'b0;
        tick();
    endtask

    // Driver: issue a line read, return latency, data, error and busy cycles.
    task automatic do_read(input logic [63:0] a, output int lat, output logic [255:0] d,
                           output logic err, output int busy_cnt);
        rd_req  = 1'b1;
        rd_addr = a;
        lat = 0;
        busy_cnt = 0;
        err = 1'b0;
        d = '0;
        while (lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
            if (rd_done) begin
                d   = rd_data;
                err = mem_err;
                break;
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done got %b exp 0", rd_done); end
        checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done got %b exp 0", wr_done); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", mem_err); end
        checks++; if (rd_data !== '0)   begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_basic();
        int lat, bc;
        logic err;
        logic [255:0] d;
        logic [63:0] dw;
        // Fill line 5 so that byte i = i.
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) dw[b*8 +: 8] = 8'(k * 8 + b);
            do_write(64'hA0 + 64'(k * 8), dw, 8'hFF, 1'b0, lat, err);
            checks++; if (lat != 3)    begin errors++; $display("FAIL fill_wr_latency[%0d] got %0d exp 3", k, lat); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_wr_err[%0d] got %b exp 0", k, err); end
        end
        for (int i = 0; i < 32; i++) exp_line[i*8 +: 8] = 8'(i);
        do_read(64'hA0, lat, d, err, bc);
        checks++; if (lat != 5)       begin errors++; $display("FAIL rd_latency got %0d exp 5", lat); end
        checks++; if (bc != 5)        begin errors++; $display("FAIL rd_busy_cycles got %0d exp 5", bc); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL rd_err got %b exp 0", err); end
        checks++; if (d !== exp_line) begin errors++; $display("FAIL rd_data got %h exp %h", d, exp_line); end
        // Low address bits are ignored on reads.
        do_read(64'hBF, lat, d, err, bc);
        checks++; if (d !== exp_line) begin errors++; $display("FAIL rd_unaligned_data got %h exp %h", d, exp_line); end
    endtask

    task automatic test_write_merge();
        int lat, bc;
        logic err;
        logic [255:0] d;
        do_write(64'hA3, 64'hBEEF, 8'h03, 1'b0, lat, err);
        checks++; if (lat != 3) begin errors++; $display("FAIL merge_wr_latency got %0d exp 3", lat); end
        exp_line[3*8 +: 8] = 8'hEF;
        exp_line[4*8 +: 8] = 8'hBE;
        do_read(64'hA0, lat, d, err, bc);
        checks++; if (d !== exp_line) begin errors++; $display("FAIL merge_data got %h exp %h", d, exp_line); end
        // Offset 6 with 4-byte strobe: only bytes 6,7 written, bytes 8,9 untouched.
        do_write(64'hA6, 64'hAABBCCDD, 8'h0F, 1'b0, lat, err);
        exp_line[6*8 +: 8] = 8'hDD;
        exp_line[7*8 +: 8] = 8'hCC;
        do_read(64'hA0, lat, d, err, bc);
        checks++; if (d !== exp_line) begin errors++; $display("FAIL merge_boundary got %h exp %h", d, exp_line); end
    endtask

    task automatic test_collision();
        int wr_cyc, rd_cyc, cyc;
        logic [255:0] d;
        wr_cyc = 0; rd_cyc = 0; cyc = 0; d = '0;
        rd_req = 1'b1; rd_addr = 64'hA0;
        wr_valid = 1'b1; wr_addr = 64'hA8; wr_data = 64'hFF; wr_strb = 8'h01;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (wr_done) begin
                wr_cyc = cyc;
                wr_valid = 1'b0;
            end
            if (rd_done) begin
                rd_cyc = cyc;
                d = rd_data;
                break;
            end
        end
        rd_req = 1'b0;
        wr_valid = 1'b0;
        tick();
        exp_line[8*8 +: 8] = 8'hFF;
        checks++; if (wr_cyc != 3)    begin errors++; $display("FAIL coll_wr_cycle got %0d exp 3", wr_cyc); end
        checks++; if (rd_cyc != 9)    begin errors++; $display("FAIL coll_rd_cycle got %0d exp 9", rd_cyc); end
        checks++; if (d !== exp_line) begin errors++; $display("FAIL coll_rd_data got %h exp %h", d, exp_line); end
    endtask

    task automatic test_out_of_range();
        int lat, bc;
        logic err;
        logic [255:0] d;
        do_write(64'h0, 64'h1122334455667788, 8'hFF, 1'b0, lat, err);
        do_read(64'h8000, lat, d, err, bc);
        checks++; if (lat != 5)     begin errors++; $display("FAIL oor_rd_latency got %0d exp 5", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b exp 1", err); end
        checks++; if (d !== '0)     begin errors++; $display("FAIL oor_rd_data got %h exp 0", d); end
        do_write(64'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, lat, err);
        checks++; if (lat != 3)     begin errors++; $display("FAIL oor_wr_latency got %0d exp 3", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", err); end
        do_read(64'h0, lat, d, err, bc);
        checks++; if (d[63:0] !== 64'h1122334455667788) begin errors++; $display("FAIL oor_no_alias got %h exp 1122334455667788", d[63:0]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL inrange_err got %b exp 0", err); end
    endtask

    task automatic test_drop_early();
        int lat, bc;
        logic err;
        logic [255:0] d;
        do_write(64'hB0, 64'h5A, 8'h01, 1'b1, lat, err);
        checks++; if (lat != 3) begin errors++; $display("FAIL drop_wr_latency got %0d exp 3", lat); end
        exp_line[16*8 +: 8] = 8'h5A;
        do_read(64'hA0, lat, d, err, bc);
        checks++; if (d !== exp_line) begin errors++; $display("FAIL drop_wr_data got %h exp %h", d, exp_line); end
    endtask

    task automatic test_hold_through_done();
        int cyc;
        logic seen;
        cyc = 0; seen = 1'b0;
        rd_req = 1'b1; rd_addr = 64'hA0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (rd_done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_done_seen got %b exp 1", seen); end
        // Request still high through DONE: next cycle must be IDLE.
        tick();
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL hold_busy_after_done got %b exp 0", busy); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL hold_second_done got %b exp 0", rd_done); end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bc, dones;
        logic err;
        logic [255:0] d;
        rd_req = 1'b1; rd_addr = 64'hA0;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mid_busy_after got %b exp 0", busy); end
        checks++; if (rd_data !== '0)   begin errors++; $display("FAIL mid_rd_data got %h exp 0", rd_data); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL mid_rd_done got %b exp 0", rd_done); end
        rst_n = 1'b1;
        rd_req = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_done || wr_done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL mid_spurious_done got %0d exp 0", dones); end
        // Abort a write in WR_WAIT: byte 0 must keep its old value.
        wr_valid = 1'b1; wr_addr = 64'hA0; wr_data = 64'h77; wr_strb = 8'h01;
        tick();
        rst_n = 1'b0;
        tick();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        do_read(64'hA0, lat, d, err, bc);
        checks++; if (d !== exp_line) begin errors++; $display("FAIL mid_mem_preserved got %h exp %h", d, exp_line); end
    endtask

    initial begin
        exp_line = '0;
        test_reset();
        test_read_basic();
        test_write_merge();
        test_collision();
        test_out_of_range();
        test_drop_early();
        test_hold_through_done();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
